async_fifo_wr_ctrl: RTL and testbench

- Write-side controller of a dual-clock FIFO. Runs entirely in the write clock domain.
- Owns the local write pointer and keeps it in binary and Gray form.
- Receives the read pointer from the read-domain Gray counter and synchronizes it with two flops. Converts that pointer back to binary and derives full, free count and the overflow flag.
- Drives the write port of the FIFO storage RAM. Its Gray pointer output feeds the read-domain synchronizer.

---
 rtl/async_fifo_wr_ctrl.sv | 122 ++++++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_ctrl
//   Write-side controller of a dual-clock FIFO, entirely in the CLK domain.
//   Keeps the write pointer in binary and Gray form. Brings the read-domain
//   Gray pointer in through a two-flop synchronizer and derives full, the
//   free-entry count and a sticky overflow flag. Drives the storage RAM
//   write port.
//
// Ports
//   CLK            write-domain clock
//   nRST           synchronous active-low reset
//   enq__ENA       enqueue request
//   enq_v          enqueue data
//   enq__RDY       FIFO not full (enqueue accepted when ENA & RDY)
//   rptrGray       read pointer, Gray code, asynchronous to CLK
//   wptrGray       registered write pointer, Gray code, to the read domain
//   freeCount      free entries, 0..2^width
//   errOverflow    sticky: enqueue attempted while full
//   ramWrite__ENA  storage write strobe
//   ramAddr        storage write address
//   ramData        storage write data
// ---------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
  parameter int width     = 4,
  parameter int dataWidth = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 enq__ENA,
  input  logic [dataWidth-1:0] enq_v,
  output logic                 enq__RDY,
  input  logic [width:0]       rptrGray,
  output logic [width:0]       wptrGray,
  output logic [width:0]       freeCount,
  output logic                 errOverflow,
  output logic                 ramWrite__ENA,
  output logic [width-1:0]     ramAddr,
  output logic [dataWidth-1:0] ramData
);

  localparam logic [width:0] PTR_ONE = {{width{1'b0}}, 1'b1};
  localparam logic [width:0] DEPTH   = {1'b1, {width{1'b0}}};

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [width:0] gray2bin(input logic [width:0] g);
    logic [width:0] b;
    b[width] = g[width];
    for (int i = width - 1; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [width:0] bin2gray(input logic [width:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [width:0] wptr_bin_q, wptr_bin_d;
  logic [width:0] wptr_gray_q, wptr_gray_d;
  logic [width:0] rsync1_q, rsync2_q;
  logic           err_overflow_q, err_overflow_d;

  logic [width:0] rptr_bin_s;
  logic [width:0] used_s;
  logic           full_s;
  logic           accept_s;
  logic           reject_s;

  // Full/free derivation and next-state for pointers and the overflow flag.
  always_comb begin
    rptr_bin_s     = gray2bin(rsync2_q);
    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the two MSBs differ, the rest match.
    full_s         = (wptr_gray_q == {~rsync2_q[width], ~rsync2_q[width-1],
                                      rsync2_q[width-2:0]});
    used_s         = wptr_bin_q - rptr_bin_s;
    // Reset wins over any enqueue presented in the same cycle.
    accept_s       = enq__ENA & ~full_s & nRST;
    reject_s       = enq__ENA & full_s;
    wptr_bin_d     = wptr_bin_q;
    wptr_gray_d    = wptr_gray_q;
    err_overflow_d = err_overflow_q;
    if (accept_s) begin
      wptr_bin_d  = wptr_bin_q + PTR_ONE;
      wptr_gray_d = bin2gray(wptr_bin_q + PTR_ONE);
    end else begin
      wptr_bin_d  = wptr_bin_q;
      wptr_gray_d = wptr_gray_q;
    end
    if (reject_s) begin
      err_overflow_d = 1'b1;
    end else begin
      err_overflow_d = err_overflow_q;
    end
  end

  // Pointer registers, read-pointer synchronizer and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr_bin_q     <= {(width + 1){1'b0}};
      wptr_gray_q    <= {(width + 1){1'b0}};
      rsync1_q       <= {(width + 1){1'b0}};
      rsync2_q       <= {(width + 1){1'b0}};
      err_overflow_q <= 1'b0;
    end else begin
      wptr_bin_q     <= wptr_bin_d;
      wptr_gray_q    <= wptr_gray_d;
      rsync1_q       <= rptrGray;
      rsync2_q       <= rsync1_q;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign enq__RDY      = ~full_s;
  assign wptrGray      = wptr_gray_q;
  assign freeCount     = DEPTH - used_s;
  assign errOverflow   = err_overflow_q;
  assign ramWrite__ENA = accept_s;
  assign ramAddr       = wptr_bin_q[width-1:0];
  assign ramData       = enq_v;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_wr_ctrl
//   Directed bench for async_fifo_wr_ctrl with width=4, dataWidth=32.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 time unit after inputs settle, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_async_fifo_wr_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq_ena;
  logic [31:0] enq_v;
  logic        enq_rdy;
  logic [4:0]  rptr_gray;
  logic [4:0]  wptr_gray;
  logic [4:0]  free_count;
  logic        err_overflow;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_data;

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-written 5-bit Gray sequence for binary 0..16.
  logic [4:0] gray_tab [0:16] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010,
                                  5'b00110, 5'b00111, 5'b00101, 5'b00100,
                                  5'b01100, 5'b01101, 5'b01111, 5'b01110,
                                  5'b01010, 5'b01011, 5'b01001, 5'b01000,
                                  5'b11000};

  async_fifo_wr_ctrl #(.width(4), .dataWidth(32)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .enq__ENA      (enq_ena),
    .enq_v         (enq_v),
    .enq__RDY      (enq_rdy),
    .rptrGray      (rptr_gray),
    .wptrGray      (wptr_gray),
    .freeCount     (free_count),
    .errOverflow   (err_overflow),
    .ramWrite__ENA (ram_we),
    .ramAddr       (ram_addr),
    .ramData       (ram_data)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int w;
    int r;
    logic [4:0] prev_g;
    logic [4:0] rb;

    // Reset held for 2 cycles with an enqueue request present.
    nRST = 1'b0; enq_ena = 1'b1; enq_v = 32'hDEAD_BEEF; rptr_gray = 5'd0;
    step();
    chk("rst_no_write1", 32'(ram_we), 32'd0);
    step();
    chk("rst_no_write2", 32'(ram_we), 32'd0);
    nRST = 1'b1; enq_ena = 1'b0;
    #1;
    chk("rst_rdy", 32'(enq_rdy), 32'd1);
    chk("rst_free", 32'(free_count), 32'd16);
    chk("rst_wgray", 32'(wptr_gray), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);

    // Fill to full with the read pointer held at 0.
    for (int i = 0; i < 16; i++) begin
      enq_ena = 1'b1; enq_v = 32'hA000 + 32'(i);
      #1;
      chk("fill_we", 32'(ram_we), 32'd1);
      chk("fill_addr", 32'(ram_addr), 32'(i));
      chk("fill_data", ram_data, 32'hA000 + 32'(i));
      step();
      chk("fill_wgray", 32'(wptr_gray), 32'(gray_tab[i + 1]));
      chk("fill_free", 32'(free_count), 32'(15 - i));
    end
    enq_ena = 1'b0;
    #1;
    chk("full_wgray", 32'(wptr_gray), 32'b11000);
    chk("full_rdy", 32'(enq_rdy), 32'd0);
    chk("full_free", 32'(free_count), 32'd0);

    // Overflow attempt while full.
    enq_ena = 1'b1; enq_v = 32'h5555_5555;
    #1;
    chk("ovf_no_write", 32'(ram_we), 32'd0);
    step();
    enq_ena = 1'b0;
    chk("ovf_wgray", 32'(wptr_gray), 32'b11000);
    chk("ovf_err", 32'(err_overflow), 32'd1);

    // Read pointer advances to 1: visible only after the second edge.
    rptr_gray = 5'b00001;
    step();
    chk("sync_rdy_edge1", 32'(enq_rdy), 32'd0);
    chk("sync_free_edge1", 32'(free_count), 32'd0);
    step();
    chk("sync_rdy_edge2", 32'(enq_rdy), 32'd1);
    chk("sync_free_edge2", 32'(free_count), 32'd1);
    chk("sync_err_sticky", 32'(err_overflow), 32'd1);

    // Drain: read pointer jumps to 16 (Gray 11000), FIFO empty.
    rptr_gray = 5'b11000;
    step();
    step();
    chk("drain_free", 32'(free_count), 32'd16);

    // Wrap: 40 enqueues with the read side trailing, occupancy kept <= 3.
    w = 16; r = 16;
    for (int k = 0; k < 40; k++) begin
      prev_g = wptr_gray;
      enq_ena = 1'b1; enq_v = 32'hC000 + 32'(k);
      #1;
      chk("wrap_we", 32'(ram_we), 32'd1);
      chk("wrap_addr", 32'(ram_addr), 32'(w % 16));
      step();
      enq_ena = 1'b0;
      w++;
      chk("wrap_one_bit", 32'($countones(prev_g ^ wptr_gray)), 32'd1);
      if (w - r > 2) begin
        r++;
        rb = 5'(r % 32);
        rptr_gray = rb ^ (rb >> 1);
      end
      step();
      step();
      chk("wrap_free", 32'(free_count), 32'(16 - (w - r)));
      chk("wrap_rdy", 32'(enq_rdy), 32'd1);
    end

    // Seven more writes, then reset with a request pending.
    for (int i = 0; i < 7; i++) begin
      enq_ena = 1'b1; enq_v = 32'hE000 + 32'(i);
      step();
    end
    w += 7;
    enq_ena = 1'b0;
    #1;
    chk("mid_free", 32'(free_count), 32'(16 - (w - r)));
    nRST = 1'b0; enq_ena = 1'b1; rptr_gray = 5'd0;
    #1;
    chk("mid_rst_no_write", 32'(ram_we), 32'd0);
    step();
    nRST = 1'b1; enq_ena = 1'b0;
    #1;
    chk("mid_rst_wgray", 32'(wptr_gray), 32'd0);
    chk("mid_rst_free", 32'(free_count), 32'd16);
    chk("mid_rst_err", 32'(err_overflow), 32'd0);
    chk("mid_rst_rdy", 32'(enq_rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
